// File: rtl/man_order_pipe.sv
// man_order_pipe: a two-stage operand-ordering pipeline for the FP add/sub datapath.
// Stage 1 registers the operands and the raw magnitude compare results.
// Stage 2 picks the larger operand, computes the exponent difference and the
// effective operation, and holds the result until downstream accepts it.
// The flow control is valid/ready and can accept one pair every cycle.
module man_order_pipe #(
  parameter int SIZE_EXP = 8,
  parameter int SIZE_MAN = 24
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic                i_sub,
  input  logic                i_sign_a,
  input  logic                i_sign_b,
  input  logic [SIZE_EXP-1:0] i_exp_a,
  input  logic [SIZE_EXP-1:0] i_exp_b,
  input  logic [SIZE_MAN-1:0] i_man_a,
  input  logic [SIZE_MAN-1:0] i_man_b,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_sign_max,
  output logic                o_sign_min,
  output logic [SIZE_EXP-1:0] o_exp_max,
  output logic [SIZE_EXP-1:0] o_exp_diff,
  output logic [SIZE_MAN-1:0] o_man_max,
  output logic [SIZE_MAN-1:0] o_man_min,
  output logic                o_eff_sub,
  output logic                o_swap,
  output logic                o_equal
);

  // Stage valid bits
  logic r_v1;
  logic r_v2;

  // Stage 1 operand and compare registers
  logic                r_sign_a;
  logic                r_sign_b;
  logic [SIZE_EXP-1:0] r_exp_a;
  logic [SIZE_EXP-1:0] r_exp_b;
  logic [SIZE_MAN-1:0] r_man_a;
  logic [SIZE_MAN-1:0] r_man_b;
  logic                r_exp_gt;
  logic                r_exp_eq;
  logic                r_man_lt;

  // Handshake controls
  logic w_load1;
  logic w_load2;
  logic w_take1;
  logic w_take2;

  // Ordered bundle, computed from the stage 1 registers
  logic                w_swap;
  logic                w_sign_max;
  logic                w_sign_min;
  logic [SIZE_EXP-1:0] w_exp_max;
  logic [SIZE_EXP-1:0] w_exp_min;
  logic [SIZE_EXP-1:0] w_exp_diff;
  logic [SIZE_MAN-1:0] w_man_max;
  logic [SIZE_MAN-1:0] w_man_min;
  logic                w_equal;

  // Stage load enables; stage 2 frees up when empty or draining, stage 1 when stage 2 moves
  always_comb begin
    w_load2 = ~r_v2 | i_ready;
    w_load1 = ~r_v1 | w_load2;
    w_take1 = w_load1 & i_valid;
    w_take2 = w_load2 & r_v1;
  end

  // The ready output is combinational from i_ready because there is no skid buffer
  assign o_ready = w_load1;
  assign o_valid = r_v2;

  // Valid bits follow the data; a stage that drains without being refilled goes empty
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else begin
      if (w_load1) r_v1 <= i_valid;
      if (w_load2) r_v2 <= r_v1;
    end
  end

  // Stage 1 captures the operands on a handshake, applying the subtract mode to B's sign
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_exp_a  <= '0;
      r_exp_b  <= '0;
      r_man_a  <= '0;
      r_man_b  <= '0;
      r_exp_gt <= 1'b0;
      r_exp_eq <= 1'b0;
      r_man_lt <= 1'b0;
    end else if (w_take1) begin
      r_sign_a <= i_sign_a;
      r_sign_b <= i_sign_b ^ i_sub;
      r_exp_a  <= i_exp_a;
      r_exp_b  <= i_exp_b;
      r_man_a  <= i_man_a;
      r_man_b  <= i_man_b;
      r_exp_gt <= (i_exp_b > i_exp_a);
      r_exp_eq <= (i_exp_a == i_exp_b);
      r_man_lt <= (i_man_a < i_man_b);
    end
  end

  // Ordering: B is the larger operand only when strictly greater, so equal magnitudes keep A on top
  always_comb begin
    w_swap     = r_exp_gt | (r_exp_eq & r_man_lt);
    w_sign_max = r_sign_a;
    w_sign_min = r_sign_b;
    w_exp_max  = r_exp_a;
    w_exp_min  = r_exp_b;
    w_man_max  = r_man_a;
    w_man_min  = r_man_b;
    if (w_swap) begin
      w_sign_max = r_sign_b;
      w_sign_min = r_sign_a;
      w_exp_max  = r_exp_b;
      w_exp_min  = r_exp_a;
      w_man_max  = r_man_b;
      w_man_min  = r_man_a;
    end else begin
      w_sign_max = r_sign_a;
      w_sign_min = r_sign_b;
      w_exp_max  = r_exp_a;
      w_exp_min  = r_exp_b;
      w_man_max  = r_man_a;
      w_man_min  = r_man_b;
    end
    w_exp_diff = w_exp_max - w_exp_min;
    w_equal    = r_exp_eq & (r_man_a == r_man_b);
  end

  // Stage 2 output registers load only on a handshake and otherwise hold for back-pressure
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_sign_max <= 1'b0;
      o_sign_min <= 1'b0;
      o_exp_max  <= '0;
      o_exp_diff <= '0;
      o_man_max  <= '0;
      o_man_min  <= '0;
      o_eff_sub  <= 1'b0;
      o_swap     <= 1'b0;
      o_equal    <= 1'b0;
    end else if (w_take2) begin
      o_sign_max <= w_sign_max;
      o_sign_min <= w_sign_min;
      o_exp_max  <= w_exp_max;
      o_exp_diff <= w_exp_diff;
      o_man_max  <= w_man_max;
      o_man_min  <= w_man_min;
      o_eff_sub  <= w_sign_max ^ w_sign_min;
      o_swap     <= w_swap;
      o_equal    <= w_equal;
    end
  end

endmodule

// File: tb/tb_man_order_pipe.sv
// Self-checking bench for man_order_pipe: directed vector table, random streams,
// back-pressure, full throughput and asynchronous reset, all through a scoreboard queue.
module tb_man_order_pipe;

  typedef struct packed {
    logic       sub;
    logic       sa;
    logic       sb;
    logic [7:0] ea;
    logic [7:0] eb;
    logic [23:0] ma;
    logic [23:0] mb;
  } in_t;

  typedef struct packed {
    logic        sm;
    logic        smin;
    logic [7:0]  em;
    logic [7:0]  ed;
    logic [23:0] mm;
    logic [23:0] mn;
    logic        eff;
    logic        sw;
    logic        eq;
  } res_t;

  typedef struct {
    in_t  i;
    res_t e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid, o_ready, i_sub, i_sign_a, i_sign_b, o_valid, i_ready;
  logic [7:0]  i_exp_a, i_exp_b;
  logic [23:0] i_man_a, i_man_b;
  logic        o_sign_max, o_sign_min, o_eff_sub, o_swap, o_equal;
  logic [7:0]  o_exp_max, o_exp_diff;
  logic [23:0] o_man_max, o_man_min;

  man_order_pipe #(.SIZE_EXP(8), .SIZE_MAN(24)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_sub(i_sub), .i_sign_a(i_sign_a), .i_sign_b(i_sign_b),
    .i_exp_a(i_exp_a), .i_exp_b(i_exp_b), .i_man_a(i_man_a), .i_man_b(i_man_b),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_sign_max(o_sign_max), .o_sign_min(o_sign_min), .o_exp_max(o_exp_max),
    .o_exp_diff(o_exp_diff), .o_man_max(o_man_max), .o_man_min(o_man_min),
    .o_eff_sub(o_eff_sub), .o_swap(o_swap), .o_equal(o_equal)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  res_t q[$];
  res_t cur_exp;
  res_t snap;
  logic hold_prev = 1'b0;
  int   rdy_mode = 0;  // 0: always ready, 1: toggle pattern, 2: stalled
  int   pidx = 0;
  logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic sec_tp = 1'b0;
  int   tp_t0, tp_first, tp_last;
  int   tp_cnt = 0;
  vec_t vecs [6];

  function automatic in_t mk_in(logic sub, logic sa, logic sb, logic [7:0] ea, logic [7:0] eb,
                                logic [23:0] ma, logic [23:0] mb);
    in_t v;
    v.sub = sub; v.sa = sa; v.sb = sb; v.ea = ea; v.eb = eb; v.ma = ma; v.mb = mb;
    return v;
  endfunction

  function automatic res_t mk_res(logic sm, logic smin, logic [7:0] em, logic [7:0] ed,
                                  logic [23:0] mm, logic [23:0] mn, logic eff, logic sw, logic eq);
    res_t r;
    r.sm = sm; r.smin = smin; r.em = em; r.ed = ed; r.mm = mm; r.mn = mn;
    r.eff = eff; r.sw = sw; r.eq = eq;
    return r;
  endfunction

  // Reference: magnitude is {exponent, mantissa} as one unsigned number
  function automatic res_t model(in_t v);
    res_t        r;
    logic        sbp;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    sbp   = v.sb ^ v.sub;
    mag_a = {v.ea, v.ma};
    mag_b = {v.eb, v.mb};
    r.sw  = (mag_b > mag_a);
    r.eq  = (mag_a == mag_b);
    if (r.sw) begin
      r.sm = sbp;  r.smin = v.sa; r.em = v.eb; r.ed = v.eb - v.ea; r.mm = v.mb; r.mn = v.ma;
    end else begin
      r.sm = v.sa; r.smin = sbp;  r.em = v.ea; r.ed = v.ea - v.eb; r.mm = v.ma; r.mn = v.mb;
    end
    r.eff = r.sm ^ r.smin;
    return r;
  endfunction

  function automatic in_t rnd_in();
    in_t v;
    v.sub = 1'($urandom_range(0, 1));
    v.sa  = 1'($urandom_range(0, 1));
    v.sb  = 1'($urandom_range(0, 1));
    v.ea  = 8'($urandom_range(0, 255));
    v.eb  = ($urandom_range(0, 2) == 0) ? v.ea : 8'($urandom_range(0, 255));
    v.ma  = 24'($urandom);
    v.mb  = ($urandom_range(0, 4) == 0) ? v.ma : 24'($urandom);
    return v;
  endfunction

  function automatic res_t dut_out();
    return {o_sign_max, o_sign_min, o_exp_max, o_exp_diff, o_man_max, o_man_min,
            o_eff_sub, o_swap, o_equal};
  endfunction

  task automatic check_bit(string name, logic act, logic req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_res(string name, res_t act, res_t req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_int(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Cycle counter
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard monitor, sampling on the falling edge
  initial forever begin
    res_t out;
    @(negedge clk);
    if (rst_n) begin
      out = dut_out();
      check_bit("o_ready", o_ready, !(q.size() == 2 && !i_ready));
      if (hold_prev) begin
        check_bit("hold_valid", o_valid, 1'b1);
        check_res("hold_data", out, snap);
      end
      if (o_valid && i_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_out: got %h expected no output", out);
        end else begin
          check_res("out_data", out, q.pop_front());
        end
        if (sec_tp) begin
          if (tp_cnt == 0) tp_first = cyc;
          tp_last = cyc;
          tp_cnt++;
        end
      end
      hold_prev = o_valid && !i_ready;
      snap = out;
      if (i_valid && o_ready) q.push_back(cur_exp);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    case (rdy_mode)
      1:       begin i_ready = pat[pidx % 6]; pidx++; end
      2:       i_ready = 1'b0;
      default: i_ready = 1'b1;
    endcase
  endtask

  task automatic drive(in_t v, res_t e);
    i_sub = v.sub; i_sign_a = v.sa; i_sign_b = v.sb;
    i_exp_a = v.ea; i_exp_b = v.eb; i_man_a = v.ma; i_man_b = v.mb;
    cur_exp = e;
    i_valid = 1'b1;
  endtask

  task automatic send(in_t v, res_t e);
    int   tries;
    logic acc;
    tries = 0;
    drive(v, e);
    do begin
      @(negedge clk);
      acc = o_ready;
      step();
      tries++;
    end while (!acc && tries < 200);
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got no accept expected accept within 200 cycles");
    end
    i_valid = 1'b0;
  endtask

  task automatic drain(string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    check_int(name, q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t v;
    rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_sub = 1'b0;
    i_sign_a = 1'b0; i_sign_b = 1'b0; i_exp_a = 8'd0; i_exp_b = 8'd0;
    i_man_a = 24'd0; i_man_b = 24'd0; cur_exp = '0;

    vecs[0].i = mk_in(1'b0, 1'b0, 1'b0, 8'd127, 8'd128, 24'h800000, 24'h800000);
    vecs[0].e = mk_res(1'b0, 1'b0, 8'd128, 8'd1, 24'h800000, 24'h800000, 1'b0, 1'b1, 1'b0);
    vecs[1].i = mk_in(1'b1, 1'b0, 1'b0, 8'd130, 8'd130, 24'h900000, 24'hC00000);
    vecs[1].e = mk_res(1'b1, 1'b0, 8'd130, 8'd0, 24'hC00000, 24'h900000, 1'b1, 1'b1, 1'b0);
    vecs[2].i = mk_in(1'b1, 1'b0, 1'b0, 8'd100, 8'd100, 24'hA00000, 24'hA00000);
    vecs[2].e = mk_res(1'b0, 1'b1, 8'd100, 8'd0, 24'hA00000, 24'hA00000, 1'b1, 1'b0, 1'b1);
    vecs[3].i = mk_in(1'b0, 1'b0, 1'b1, 8'd131, 8'd130, 24'h800000, 24'hFFFFFF);
    vecs[3].e = mk_res(1'b0, 1'b1, 8'd131, 8'd1, 24'h800000, 24'hFFFFFF, 1'b1, 1'b0, 1'b0);
    vecs[4].i = mk_in(1'b1, 1'b1, 1'b0, 8'd0, 8'd255, 24'h000001, 24'h7FFFFF);
    vecs[4].e = mk_res(1'b1, 1'b1, 8'd255, 8'd255, 24'h7FFFFF, 24'h000001, 1'b0, 1'b1, 1'b0);
    vecs[5].i = mk_in(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 24'h000000, 24'h000000);
    vecs[5].e = mk_res(1'b0, 1'b0, 8'd0, 8'd0, 24'h000000, 24'h000000, 1'b0, 1'b0, 1'b1);

    // Reset state, including ready while downstream is stalled
    #12;
    check_bit("rst_valid", o_valid, 1'b0);
    check_res("rst_data", dut_out(), '0);
    check_bit("rst_ready", o_ready, 1'b1);
    i_ready = 1'b0;
    #1;
    check_bit("rst_ready_stall", o_ready, 1'b1);
    i_ready = 1'b1;
    step();
    rst_n = 1'b1;
    step();

    // Directed table
    foreach (vecs[k]) send(vecs[k].i, vecs[k].e);
    drain("drain_directed");

    // Full throughput and two-cycle latency
    sec_tp = 1'b1;
    tp_t0 = cyc;
    for (int k = 0; k < 100; k++) begin
      v = rnd_in();
      send(v, model(v));
    end
    drain("drain_tp");
    step();
    sec_tp = 1'b0;
    check_int("tp_latency", tp_first - tp_t0, 2);
    check_int("tp_count", tp_cnt, 100);
    check_int("tp_span", tp_last - tp_first, 99);

    // Back-pressure with toggling downstream ready
    rdy_mode = 1;
    pidx = 0;
    for (int k = 0; k < 6; k++) begin
      v = rnd_in();
      send(v, model(v));
    end
    drain("drain_bp");
    rdy_mode = 0;
    repeat (3) step();

    // Fill both stages with downstream stalled, then reset mid-cycle
    rdy_mode = 2;
    step();
    for (int k = 0; k < 2; k++) begin
      v = rnd_in();
      send(v, model(v));
    end
    v = rnd_in();
    drive(v, model(v));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_bit("bp_full_ready", o_ready, 1'b0);
      check_bit("bp_full_valid", o_valid, 1'b1);
      step();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_bit("midrst_valid", o_valid, 1'b0);
    check_res("midrst_data", dut_out(), '0);
    check_bit("midrst_ready", o_ready, 1'b1);
    i_valid = 1'b0;
    q.delete();
    hold_prev = 1'b0;
    rdy_mode = 0;
    step();
    rst_n = 1'b1;
    step();
    send(mk_in(1'b0, 1'b0, 1'b0, 8'd128, 8'd126, 24'hC00000, 24'h800000),
         mk_res(1'b0, 1'b0, 8'd128, 8'd2, 24'hC00000, 24'h800000, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    check_bit("post_rst_lat1", o_valid, 1'b0);
    step();
    @(negedge clk);
    check_bit("post_rst_lat2", o_valid, 1'b1);
    drain("drain_post_rst");
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
